// File: rtl/lbp.sv
`default_nettype none
// ============================================================================
// Module   : lbp
// Purpose  : 3x3 Local Binary Pattern engine over a 128x128 8-bit image, read
//            through a request/address port and written to a result memory.
//            Optional macro LBP_BORDER_WRITE_EN zero-fills the 508 border codes.
// Revision : 1.0  initial release
// ============================================================================
module lbp (
  input  logic        clk,
  input  logic        reset,
  input  logic        gray_ready,
  output logic        gray_req,
  output logic [13:0] gray_addr,
  input  logic [7:0]  gray_data,
  output logic        lbp_valid,
  output logic [13:0] lbp_addr,
  output logic [7:0]  lbp_data,
  output logic        finish
);

  localparam logic [6:0] C_LAST  = 7'd126;
  localparam logic [6:0] C_EDGE  = 7'd127;
  localparam logic [3:0] C_NLOAD = 4'd9;
  localparam logic [3:0] C_NSHFT = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHIFT  = 3'd2,
    S_WRITE  = 3'd3,
    S_BORDER = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t r_state, w_next;

  logic [6:0]            r_row, r_col;
  logic [3:0]            r_iss, r_cap;
  logic [2:0][2:0][7:0]  r_win;

  logic       w_issue;
  logic [6:0] w_rd_row, w_rd_col;
  logic [3:0] w_iss_slot, w_cap_slot;
  logic [7:0] w_ctr, w_code;

  // Row load is column-major: index -> {row offset, column offset}.
  function automatic logic [3:0] slot(input logic [3:0] idx);
    case (idx)
      4'd0:    slot = {2'd0, 2'd0};
      4'd1:    slot = {2'd1, 2'd0};
      4'd2:    slot = {2'd2, 2'd0};
      4'd3:    slot = {2'd0, 2'd1};
      4'd4:    slot = {2'd1, 2'd1};
      4'd5:    slot = {2'd2, 2'd1};
      4'd6:    slot = {2'd0, 2'd2};
      4'd7:    slot = {2'd1, 2'd2};
      default: slot = {2'd2, 2'd2};
    endcase
  endfunction

  assign w_iss_slot = slot(r_iss);
  assign w_cap_slot = slot(r_cap);
  assign w_ctr      = r_win[1][1];

  always_comb begin
    w_code    = '0;
    w_code[0] = (r_win[0][0] >= w_ctr);
    w_code[1] = (r_win[0][1] >= w_ctr);
    w_code[2] = (r_win[0][2] >= w_ctr);
    w_code[3] = (r_win[1][0] >= w_ctr);
    w_code[4] = (r_win[1][2] >= w_ctr);
    w_code[5] = (r_win[2][0] >= w_ctr);
    w_code[6] = (r_win[2][1] >= w_ctr);
    w_code[7] = (r_win[2][2] >= w_ctr);
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_issue  = 1'b0;
    w_rd_row = r_row;
    w_rd_col = r_col;
    case (r_state)
      S_IDLE: begin
        if (gray_ready) w_next = S_LOAD;
      end
      S_LOAD: begin
        if (r_iss < C_NLOAD) begin
          w_issue  = 1'b1;
          w_rd_row = r_row - 7'd1 + {5'd0, w_iss_slot[3:2]};
          w_rd_col = r_col - 7'd1 + {5'd0, w_iss_slot[1:0]};
        end
        if (gray_req && r_cap == C_NLOAD - 4'd1) w_next = S_WRITE;
      end
      S_SHIFT: begin
        if (r_iss < C_NSHFT) begin
          w_issue  = 1'b1;
          w_rd_row = r_row - 7'd1 + {5'd0, r_iss[1:0]};
          w_rd_col = r_col + 7'd1;
        end
        if (gray_req && r_cap == C_NSHFT - 4'd1) w_next = S_WRITE;
      end
      S_WRITE: begin
        if (r_col < C_LAST) begin
          // The first read of the next column overlaps the write cycle.
          w_next   = S_SHIFT;
          w_issue  = 1'b1;
          w_rd_row = r_row - 7'd1;
          w_rd_col = r_col + 7'd2;
        end else if (r_row < C_LAST) begin
          w_next = S_LOAD;
        end else begin
`ifdef LBP_BORDER_WRITE_EN
          w_next = S_BORDER;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef LBP_BORDER_WRITE_EN
      S_BORDER: begin
        if (r_row == C_EDGE && r_col == C_EDGE) w_next = S_DONE;
      end
`endif
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gray_req  <= 1'b0;
      gray_addr <= '0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      finish    <= 1'b0;
      r_row     <= 7'd1;
      r_col     <= 7'd1;
      r_iss     <= '0;
      r_cap     <= '0;
      r_win     <= '0;
    end else begin
      gray_req  <= w_issue;
      if (w_issue) gray_addr <= {w_rd_row, w_rd_col};
      lbp_valid <= 1'b0;
      finish    <= finish | (r_state == S_DONE);

      if (r_state == S_LOAD || r_state == S_SHIFT) begin
        if (w_issue) r_iss <= r_iss + 4'd1;
        if (gray_req) r_cap <= r_cap + 4'd1;
      end else begin
        r_iss <= w_issue ? 4'd1 : 4'd0;
        r_cap <= '0;
      end

      case (r_state)
        S_LOAD: begin
          if (gray_req) r_win[w_cap_slot[3:2]][w_cap_slot[1:0]] <= gray_data;
        end
        S_SHIFT: begin
          if (gray_req) r_win[r_cap[1:0]][2] <= gray_data;
        end
        S_WRITE: begin
          lbp_valid <= 1'b1;
          lbp_addr  <= {r_row, r_col};
          lbp_data  <= w_code;
          if (r_col < C_LAST) begin
            r_col <= r_col + 7'd1;
            for (int i = 0; i < 3; i++) begin
              r_win[i][0] <= r_win[i][1];
              r_win[i][1] <= r_win[i][2];
            end
          end else if (r_row < C_LAST) begin
            r_row <= r_row + 7'd1;
            r_col <= 7'd1;
          end else begin
            r_row <= '0;
            r_col <= '0;
          end
        end
`ifdef LBP_BORDER_WRITE_EN
        S_BORDER: begin
          lbp_valid <= 1'b1;
          lbp_addr  <= {r_row, r_col};
          lbp_data  <= '0;
          // Top/bottom rows walk every column; other rows visit only col 0 and 127.
          if (r_row == 7'd0 || r_row == C_EDGE) begin
            if (r_col == C_EDGE) begin
              r_col <= '0;
              r_row <= r_row + 7'd1;
            end else begin
              r_col <= r_col + 7'd1;
            end
          end else if (r_col == 7'd0) begin
            r_col <= C_EDGE;
          end else begin
            r_col <= '0;
            r_row <= r_row + 7'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lbp.sv
`default_nettype none
// Directed self-checking bench for lbp: composite image (constant, spike,
// horizontal ramp, vertical ramp bands), mid-frame reset and full rerun.
module tb_lbp;

  logic        clk = 1'b0;
  logic        reset;
  logic        gray_ready;
  logic        gray_req;
  logic [13:0] gray_addr;
  wire  [7:0]  gray_data;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;

  logic [7:0] img    [0:16383];
  logic [7:0] res    [0:16383];
  int         wr_cnt [0:16383];

  int checks   = 0;
  int failures = 0;
  int wcount   = 0;
  int req_early = 0;
  int post_fin = 0;
  int cyc      = 0;
  logic clr = 1'b0;

`ifdef LBP_BORDER_WRITE_EN
  localparam int EXP_WRITES = 16384;
  localparam int EXP_BORDER = 1;
  localparam int MAX_CYC    = 71000;
`else
  localparam int EXP_WRITES = 15876;
  localparam int EXP_BORDER = 0;
  localparam int MAX_CYC    = 70000;
`endif

  lbp dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish)
  );

  always #5 clk = ~clk;

  // Poison value outside requested cycles exposes any unrequested sampling.
  assign gray_data = gray_req ? img[gray_addr] : 8'h3C;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < 16384; i++) begin
        res[i]    = 8'h00;
        wr_cnt[i] = 0;
      end
      wcount = 0;
    end else if (lbp_valid) begin
      res[lbp_addr] = lbp_data;
      wr_cnt[lbp_addr]++;
      wcount++;
    end
    if (gray_req && !gray_ready) req_early++;
    if (finish && (gray_req || lbp_valid)) post_fin++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_lbp(input int r, input int k);
    logic [7:0] c;
    logic [7:0] code;
    c       = img[r*128 + k];
    code[0] = (img[(r-1)*128 + k-1] >= c);
    code[1] = (img[(r-1)*128 + k  ] >= c);
    code[2] = (img[(r-1)*128 + k+1] >= c);
    code[3] = (img[ r   *128 + k-1] >= c);
    code[4] = (img[ r   *128 + k+1] >= c);
    code[5] = (img[(r+1)*128 + k-1] >= c);
    code[6] = (img[(r+1)*128 + k  ] >= c);
    code[7] = (img[(r+1)*128 + k+1] >= c);
    return code;
  endfunction

  task automatic clear_results();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  int n, t0, bad, bad_cnt, bad_b, bad_bv, bad_a, bad_b2, bad_c;
  logic is_border;

  initial begin
    reset      = 1'b0;
    gray_ready = 1'b0;
    for (int r = 0; r < 128; r++)
      for (int k = 0; k < 128; k++) begin
        if (r <= 40)      img[r*128 + k] = (k < 64) ? 8'h5A : 8'h80;
        else if (r <= 80) img[r*128 + k] = k[7:0];
        else              img[r*128 + k] = r[7:0];
      end
    img[20*128 + 96] = 8'h00;

    clear_results();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gray_req",  {63'd0, gray_req},  64'd0);
    check("rst_gray_addr", {50'd0, gray_addr}, 64'd0);
    check("rst_lbp_valid", {63'd0, lbp_valid}, 64'd0);
    check("rst_lbp_addr",  {50'd0, lbp_addr},  64'd0);
    check("rst_lbp_data",  {56'd0, lbp_data},  64'd0);
    check("rst_finish",    {63'd0, finish},    64'd0);

    @(negedge clk) reset = 1'b1;
    repeat (50) @(posedge clk);
    #1 check("no_req_before_ready", req_early, 0);

    @(negedge clk) gray_ready = 1'b1;
    n = 0;
    while (wcount < 3000 && n < 20000) begin @(posedge clk); n++; end
    check("partial_progress", {63'd0, wcount >= 3000}, 64'd1);

    bad = 0;
    for (int r = 1; r <= 126; r++)
      for (int k = 1; k <= 126; k++)
        if (wr_cnt[r*128+k] > 1 || (wr_cnt[r*128+k] == 1 && res[r*128+k] !== ref_lbp(r, k))) bad++;
    check("partial_results", bad, 0);

    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("midreset_outputs", {24'd0, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish}, 64'd0);

    clear_results();
    @(negedge clk) reset = 1'b1;
    t0 = cyc;
    n = 0;
    while (finish !== 1'b1 && n < 80000) begin @(posedge clk); n++; end
    #1 check("finish_reached", {63'd0, finish}, 64'd1);
    check("runtime_in_budget", {63'd0, (cyc - t0) <= MAX_CYC}, 64'd1);
    check("write_pulses", wcount, EXP_WRITES);

    bad_cnt = 0; bad_b = 0; bad_bv = 0; bad = 0;
    for (int r = 0; r < 128; r++)
      for (int k = 0; k < 128; k++) begin
        is_border = (r == 0 || r == 127 || k == 0 || k == 127);
        if (is_border) begin
          if (wr_cnt[r*128+k] != EXP_BORDER) bad_b++;
          if (res[r*128+k] !== 8'h00) bad_bv++;
        end else begin
          if (wr_cnt[r*128+k] != 1) bad_cnt++;
          if (res[r*128+k] !== ref_lbp(r, k)) bad++;
        end
      end
    check("interior_write_once", bad_cnt, 0);
    check("border_write_count", bad_b, 0);
    check("border_value_zero", bad_bv, 0);
    check("interior_vs_model", bad, 0);

    bad_a = 0; bad_b2 = 0; bad_c = 0;
    for (int r = 1; r <= 39; r++)
      for (int k = 1; k <= 126; k++)
        if ((k <= 62 || k >= 65) && !(r >= 19 && r <= 21 && k >= 95 && k <= 97) &&
            res[r*128+k] !== 8'hFF) bad_a++;
    for (int r = 42; r <= 79; r++)
      for (int k = 1; k <= 126; k++)
        if (res[r*128+k] !== 8'hD6) bad_b2++;
    for (int r = 82; r <= 126; r++)
      for (int k = 1; k <= 126; k++)
        if (res[r*128+k] !== 8'hF8) bad_c++;
    check("const_band_ff", bad_a, 0);
    check("hramp_band_d6", bad_b2, 0);
    check("vramp_band_f8", bad_c, 0);

    check("spike_centre",  {56'd0, res[20*128+96]}, 64'hFF);
    check("spike_ul",      {56'd0, res[19*128+95]}, 64'h7F);
    check("spike_lr",      {56'd0, res[21*128+97]}, 64'hFE);
    check("spike_up",      {56'd0, res[19*128+96]}, 64'hBF);

    repeat (30) @(posedge clk);
    #1;
    check("quiet_after_finish", post_fin, 0);
    check("finish_sticky", {63'd0, finish}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lbp.md
# lbp

Local Binary Pattern engine for a 128×128 8-bit grayscale image. It reads pixels from an external gray-image memory through a request/address port and computes the 8-bit LBP code of every interior pixel. Each code is written to an external result memory at the same linear address. It sits between the image-source memory and the LBP result memory, and signals completion with `finish`.

## Interface
Parameters: none (image geometry fixed at 128×128, 14-bit linear address = row*128 + col).
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- gray_ready  input  1  image memory ready; no request may be issued before it is seen high.
- gray_req  output  1  read request; gray_data is valid only for cycles following a request.
- gray_addr  output  14  read address, registered.
- gray_data  input  8  pixel returned for the address presented while gray_req was high; sampled on the next rising edge.
- lbp_valid  output  1  result write strobe (memory captures on falling edge while high).
- lbp_addr  output  14  result address, registered.
- lbp_data  output  8  LBP code, registered.
- finish  output  1  all results written; sticky until reset.

## Operation
- Neighbour bit order around centre c = (r,k): bit0 (r-1,k-1), bit1 (r-1,k), bit2 (r-1,k+1), bit3 (r,k-1), bit4 (r,k+1), bit5 (r+1,k-1), bit6 (r+1,k), bit7 (r+1,k+1).
- Bit p = 1 when the neighbour is ≥ the centre (unsigned 8-bit compare; ties give 1).
- Processing order: raster order over interior centres, r = 1..126, k = 1..126.
- 3×3 window held in registers:
  - At the start of each row, 9 reads load the window.
  - Each step right shifts the window left and reads only the 3 pixels of the new right column.
- FSM states:
  - IDLE: wait for gray_ready.
  - LOAD: 9 reads.
  - SHIFT: 3 reads.
  - WRITE: one lbp_valid cycle.
  - DONE.
- FSM transitions:
  - IDLE→LOAD when gray_ready.
  - LOAD/SHIFT→WRITE after the last datum is captured.
  - WRITE→SHIFT while k<126.
  - WRITE→LOAD at the next row start when k=126 and r<126.
  - WRITE→DONE at r=126, k=126.
- Border pixels (row 0/127, column 0/127) handling is set by the macro in Configuration.
- Reset mid-operation:
  - Abandons the current frame and returns to IDLE.
  - Counters and window are cleared.
  - The next frame restarts from (1,1).

## Timing
- Reset values: gray_req=0, gray_addr=0, lbp_valid=0, lbp_addr=0, lbp_data=0, finish=0.
- Read latency: gray_req/gray_addr registered at edge N, gray_data captured at edge N+1. One read is issued per cycle, back-to-back allowed.
- gray_req is low in every cycle no read is needed. gray_data is don't-care (may be Z) then and must not be sampled.
- lbp_valid is high for exactly one cycle per result, with lbp_addr/lbp_data stable for that whole cycle.
- finish rises one cycle after the final lbp_valid cycle and remains high until reset. No further gray_req or lbp_valid pulses occur after finish.
- Total run time from gray_ready to finish:
  - ≤ 70,000 cycles with LBP_BORDER_WRITE_EN undefined.
  - ≤ 71,000 cycles with it defined.

## Configuration
- Macro LBP_BORDER_WRITE_EN.
- Defined: after the interior pass, the 508 border addresses are written with lbp_data=0x00, one per cycle, before finish.
- Undefined: border addresses are never written. The result memory is required to be zero-initialised.
- Interior results are identical in both builds.

## Test plan
- Constant image (all 0x5A) → every interior result 0xFF, borders 0x00, finish asserted.
- Horizontal ramp, pixel = col → every interior result 0xD6.
- Vertical ramp, pixel = row → every interior result 0xF8.
- All 0x80 except pixel (64,64)=0x00 → centre (64,64)=0xFF, (63,63)=0x7F, (65,65)=0xFE, (63,64)=0xBF, all other interior results 0xFF.
- Handshake:
  - gray_ready held low 50 cycles after reset → no gray_req until it rises.
  - Check that gray_data is never used without a preceding gray_req.
  - Exactly 15,876 interior lbp_valid pulses, or 16,384 total with LBP_BORDER_WRITE_EN.
- Reset low mid-frame (after about 3,000 writes) → all outputs return to reset values next edge. The rerun then produces the full correct image and finish.
